// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding and counter sizing for the PLL reset sequencer
package pll_seq_pkg;

    typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, STABILIZE, RUN} pll_seq_state_t;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > 1 ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous bit
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    // shift the asynchronous input through the flop chain, clearing on reset
    always_ff @(posedge clk)
        sr <= rst ? '0 : {sr[STAGES-2:0], d};

    assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds PLL in reset, waits for stable lock, then releases system reset
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       lock_lost,
    output logic       timeout,
    output logic [7:0] retry_count
);

    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam logic [CW-1:0] PR_LOAD = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LT_LOAD = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SC_LOAD = CW'(STABLE_CYCLES - 1);

    logic           lk;
    logic           to_nx;
    logic           lost_nx;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;
    pll_seq_state_t state;
    pll_seq_state_t state_nx;

    // the shared counter runs down from the state's duration; zero marks its last cycle
    function automatic logic [CW-1:0] load(input pll_seq_state_t s);
        return s == PLL_RST ? PR_LOAD : s == WAIT_LOCK ? LT_LOAD : s == STABILIZE ? SC_LOAD : '0;
    endfunction

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    // next state, counter and event pulses; any state change reloads the counter
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt == '0 ? '0 : cnt - CW'(1);
        to_nx    = 1'b0;
        lost_nx  = 1'b0;
        case (state)
            PLL_RST:   state_nx = cnt == '0 ? WAIT_LOCK : PLL_RST;
            WAIT_LOCK: begin
                state_nx = lk ? STABILIZE : cnt == '0 ? PLL_RST : WAIT_LOCK;
                to_nx    = !lk && cnt == '0;
            end
            STABILIZE: state_nx = !lk ? WAIT_LOCK : cnt == '0 ? RUN : STABILIZE;
            RUN: begin
                state_nx = lk ? RUN : PLL_RST;
                lost_nx  = !lk;
            end
            default:   state_nx = PLL_RST;
        endcase
        if (state_nx != state)
            cnt_nx = load(state_nx);
    end

    // state register with outputs decoded from the next state so they move on the transition edge
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= PLL_RST;
            cnt         <= PR_LOAD;
            pll_rst     <= 1'b1;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
            timeout     <= 1'b0;
            retry_count <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pll_rst     <= state_nx == PLL_RST;
            sys_rst     <= state_nx != RUN;
            ready       <= state_nx == RUN;
            lock_lost   <= lost_nx;
            timeout     <= to_nx;
            if (to_nx && retry_count != 8'hFF)
                retry_count <= retry_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: directed and randomized checks against a behavioural sequencer model
module tb_pll_reset_sequencer;

    localparam int PR = 4;
    localparam int LT = 100;
    localparam int SC = 16;
    localparam int S_PLL = 0;
    localparam int S_SYS = 1;
    localparam int S_TO  = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       lock_lost;
    logic       timeout;
    logic [7:0] retry_count;

    int tests = 0;
    int fails = 0;

    always #10 refclk = ~refclk;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (PR),
        .LOCK_TIMEOUT   (LT),
        .STABLE_CYCLES  (SC),
        .SYNC_STAGES    (2)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .timeout     (timeout),
        .retry_count (retry_count)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: phase 0=pll reset, 1=waiting for lock, 2=stabilizing, 3=running;
    // m_n is the number of cycles already spent in the phase, lock seen two samples late
    int m_ph, m_n, m_retry;
    bit m_lost, m_to, m_valid, m_lk;
    bit hist[$];

    always @(posedge refclk) begin
        if (rst) begin
            m_ph = 0; m_n = 0; m_retry = 0; m_lost = 0; m_to = 0; m_valid = 1;
            hist.delete();
        end else begin
            m_lk = hist.size() == 2 ? hist[0] : 1'b0;
            hist.push_back(pll_locked);
            if (hist.size() > 2) void'(hist.pop_front());
            m_lost = 0;
            m_to = 0;
            m_n++;
            if (m_ph == 0 && m_n == PR) begin
                m_ph = 1; m_n = 0;
            end else if (m_ph == 1 && m_lk) begin
                m_ph = 2; m_n = 0;
            end else if (m_ph == 1 && m_n == LT) begin
                m_ph = 0; m_n = 0; m_to = 1;
                m_retry = m_retry < 255 ? m_retry + 1 : 255;
            end else if (m_ph == 2 && !m_lk) begin
                m_ph = 1; m_n = 0;
            end else if (m_ph == 2 && m_n == SC) begin
                m_ph = 3; m_n = 0;
            end else if (m_ph == 3 && !m_lk) begin
                m_ph = 0; m_n = 0; m_lost = 1;
            end
        end
    end

    always @(negedge refclk) begin
        if (m_valid) begin
            chk("pll_rst", pll_rst, m_ph == 0);
            chk("sys_rst", sys_rst, m_ph != 3);
            chk("ready", ready, m_ph == 3);
            chk("lock_lost", lock_lost, m_lost);
            chk("timeout", timeout, m_to);
            chk("retry_count", retry_count, m_retry);
        end
    end

    function automatic int sig(input int sel);
        return sel == S_PLL ? int'(pll_rst) : sel == S_SYS ? int'(sys_rst) : int'(timeout);
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    // counts negedges until the selected output reaches val; exp<0 only requires it to be reached
    task automatic wait_until(input string nm, input int sel, input int val, input int maxc, input int exp);
        int k = 0;
        do begin
            @(negedge refclk);
            k++;
        end while (sig(sel) != val && k < maxc);
        if (exp < 0) chk(nm, int'(sig(sel) == val), 1);
        else chk(nm, k, exp);
    endtask

    task automatic reset_vals();
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_sys_rst", sys_rst, 1);
        chk("rst_ready", ready, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_retry", retry_count, 0);
    endtask

    initial begin
        int n, k, hold;
        cyc(3);
        reset_vals();
        rst = 1'b0;
        wait_until("pll_rst_width", S_PLL, 0, 50, PR);
        cyc(10);
        pll_locked = 1'b1;
        wait_until("lock_to_release", S_SYS, 0, 200, 1 + 2 + SC);
        chk("ready_after_release", ready, 1);
        chk("pll_rst_in_run", pll_rst, 0);
        cyc(5);
        pll_locked = 1'b0;
        wait_until("loss_to_sys_rst", S_SYS, 1, 50, 3);
        chk("lock_lost_pulse", lock_lost, 1);
        chk("pll_rst_on_loss", pll_rst, 1);
        chk("ready_on_loss", ready, 0);
        cyc(1);
        chk("lock_lost_single", lock_lost, 0);
        wait_until("relock_pll_rst", S_PLL, 0, 50, PR - 1);
        pll_locked = 1'b1;
        wait_until("relock_release", S_SYS, 0, 200, 1 + 2 + SC);
        chk("retry_after_loss", retry_count, 0);
        rst = 1'b1;
        cyc(1);
        reset_vals();
        rst = 1'b0;
        pll_locked = 1'b0;
        wait_until("glitch_pll_rst", S_PLL, 0, 50, PR);
        pll_locked = 1'b1;
        cyc(11);
        pll_locked = 1'b0;
        cyc(1);
        pll_locked = 1'b1;
        wait_until("glitch_release", S_SYS, 0, 200, 1 + 2 + SC);
        chk("glitch_retry", retry_count, 0);
        rst = 1'b1;
        pll_locked = 1'b0;
        cyc(1);
        reset_vals();
        rst = 1'b0;
        wait_until("stab_pll_rst", S_PLL, 0, 50, PR);
        pll_locked = 1'b1;
        cyc(8);
        rst = 1'b1;
        cyc(1);
        reset_vals();
        rst = 1'b0;
        pll_locked = 1'b0;
        wait_until("to_pll_rst", S_PLL, 0, 50, PR);
        wait_until("timeout_delay", S_TO, 1, 200, LT);
        chk("retry_first", retry_count, 1);
        chk("pll_rst_on_timeout", pll_rst, 1);
        wait_until("retry_pll_rst", S_PLL, 0, 50, PR);
        n = 0;
        k = 0;
        while (n < 299 && k < 40000) begin
            @(negedge refclk);
            k++;
            if (timeout) n++;
        end
        chk("timeouts_seen", n, 299);
        chk("retry_saturated", retry_count, 255);
        pll_locked = 1'b1;
        wait_until("sat_release", S_SYS, 0, 300, -1);
        chk("retry_kept_in_run", retry_count, 255);
        rst = 1'b1;
        cyc(1);
        reset_vals();
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            hold = $urandom_range(1, 40);
            pll_locked = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 40) == 0;
            cyc(1);
            rst = 1'b0;
            cyc(hold);
        end
        rst = 1'b0;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
